// File: rtl/cb_bl_wl_programmer_if.sv
// Configuration stream and bit-line/word-line bundle between the tile fabric and the BL/WL programmer.
interface cb_bl_wl_programmer_if #(
  parameter int BL_WIDTH = 72,
  parameter int WL_WIDTH = 72,
  parameter int WORD_W   = 8
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [WORD_W-1:0]   cfg_data;
  logic [0:BL_WIDTH-1] bl;
  logic [0:WL_WIDTH-1] wl;
  logic                busy;
  logic                done;
  logic                addr_err;

  modport master (
    output cfg_valid, cfg_data,
    input  cfg_ready, bl, wl, busy, done, addr_err
  );

  modport slave (
    input  cfg_valid, cfg_data,
    output cfg_ready, bl, wl, busy, done, addr_err
  );
endinterface

// File: rtl/cb_bl_wl_programmer.sv
// Memory-bank programmer: assembles a bit-line vector from a byte stream, then fires one word-line pulse.
module cb_bl_wl_programmer #(
  parameter int BL_WIDTH     = 72,
  parameter int WL_WIDTH     = 72,
  parameter int WORD_W       = 8,
  parameter int ADDR_W       = 7,
  parameter int PULSE_CYCLES = 2
) (
  input  logic                  prog_clk,
  input  logic                  prog_rst_n,
  cb_bl_wl_programmer_if.slave  cfg
);
  localparam int NBEATS = BL_WIDTH / WORD_W;
  localparam int BCNT_W = $clog2(NBEATS + 1);
  localparam int PCNT_W = $clog2(PULSE_CYCLES + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_PULSE = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]          r_state;
  logic [2:0]          w_state_next;
  logic [ADDR_W-1:0]   r_row;
  logic [BCNT_W-1:0]   r_beat;
  logic [PCNT_W-1:0]   r_pcnt;
  logic                r_ready_en;
  logic [BL_WIDTH-1:0] r_bl;
  logic [0:WL_WIDTH-1] r_wl;
  logic [0:BL_WIDTH-1] w_bl;
  logic                w_accept;
  logic                w_last_beat;
  logic                w_pulse_end;
  logic                w_row_ok;

  assign w_accept    = cfg.cfg_valid & cfg.cfg_ready;
  assign w_last_beat = (r_beat == BCNT_W'(NBEATS - 1));
  assign w_pulse_end = (r_pcnt == PCNT_W'(PULSE_CYCLES - 1));
  assign w_row_ok    = (int'(r_row) < WL_WIDTH);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_LOAD;
      S_LOAD:  if (w_accept && w_last_beat) w_state_next = S_SETUP;
      S_SETUP: w_state_next = S_PULSE;
      S_PULSE: if (w_pulse_end) w_state_next = S_HOLD;
      S_HOLD:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_beat     <= '0;
      r_pcnt     <= '0;
      r_ready_en <= 1'b0;
      r_bl       <= '0;
      r_wl       <= '0;
    end else begin
      r_state    <= w_state_next;
      r_ready_en <= 1'b1;
      if (r_state == S_IDLE && w_accept) begin
        r_row  <= cfg.cfg_data[ADDR_W-1:0];
        r_beat <= '0;
      end
      // bl is only ever written here, so it cannot move while a word-line is high
      if (r_state == S_LOAD && w_accept) begin
        r_beat <= r_beat + 1'b1;
        for (int k = 0; k < NBEATS; k++) begin
          if (int'(r_beat) == k) r_bl[k*WORD_W +: WORD_W] <= cfg.cfg_data;
        end
      end
      if (r_state == S_SETUP) begin
        r_pcnt <= '0;
        for (int i = 0; i < WL_WIDTH; i++) begin
          r_wl[i] <= w_row_ok && (int'(r_row) == i);
        end
      end
      if (r_state == S_PULSE) begin
        r_pcnt <= r_pcnt + 1'b1;
        if (w_pulse_end) r_wl <= '0;
      end
    end
  end

  // Internal vector is little-endian so slice writes map cfg_data[j] onto bl[k*WORD_W+j]
  genvar gi;
  generate
    for (gi = 0; gi < BL_WIDTH; gi++) begin : g_bl_map
      assign w_bl[gi] = r_bl[gi];
    end
  endgenerate

  assign cfg.bl        = w_bl;
  assign cfg.wl        = r_wl;
  assign cfg.cfg_ready = r_ready_en & ((r_state == S_IDLE) | (r_state == S_LOAD));
  assign cfg.busy      = (r_state != S_IDLE);
  assign cfg.done      = (r_state == S_HOLD);
  assign cfg.addr_err  = (r_state == S_HOLD) & ~w_row_ok;
endmodule

// File: tb/tb_cb_bl_wl_programmer.sv
// Directed + randomized frames for cb_bl_wl_programmer, checked cycle by cycle against a frame-level timeline model.
module tb_cb_bl_wl_programmer;
  localparam int BLW = 72;
  localparam int WLW = 72;
  localparam int WW  = 8;
  localparam int AW  = 7;
  localparam int PC  = 2;
  localparam int NB  = BLW / WW;

  logic prog_clk   = 1'b0;
  logic prog_rst_n = 1'b0;
  int   n_assert   = 0;
  int   n_fail     = 0;
  logic [7:0]     fd [NB];
  logic [0:BLW-1] last_bl;

  cb_bl_wl_programmer_if #(.BL_WIDTH(BLW), .WL_WIDTH(WLW), .WORD_W(WW)) bus ();

  cb_bl_wl_programmer #(
    .BL_WIDTH(BLW), .WL_WIDTH(WLW), .WORD_W(WW), .ADDR_W(AW), .PULSE_CYCLES(PC)
  ) dut (
    .prog_clk   (prog_clk),
    .prog_rst_n (prog_rst_n),
    .cfg        (bus)
  );

  always #5 prog_clk = ~prog_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Holds reset, checks the cleared outputs, releases mid-cycle and checks ready comes up one edge later.
  task automatic release_reset();
    prog_rst_n = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    repeat (3) @(posedge prog_clk);
    @(negedge prog_clk);
    chk("rst_ready", bus.cfg_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.addr_err, 0);
    chk("rst_wl", bus.wl, 0);
    chk("rst_bl", bus.bl, 0);
    #2 prog_rst_n = 1'b1;
    #1 chk("rel_ready_pre", bus.cfg_ready, 0);
    @(posedge prog_clk); #1;
    chk("rel_ready_post", bus.cfg_ready, 1);
    chk("rel_busy", bus.busy, 0);
    chk("rel_done", bus.done, 0);
    $display("reset released");
  endtask

  task automatic frame(input logic [7:0] addr, input int maxgap, input bit abort_in_pulse);
    logic [0:BLW-1] exp_bl;
    logic [0:WLW-1] exp_wl;
    int row, ncyc, gaps, wait_c, g;
    bit acc;
    row = int'(addr[AW-1:0]);
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < WW; j++) exp_bl[k*WW + j] = fd[k][j];
    exp_wl = '0;
    if (row < WLW) exp_wl[row] = 1'b1;

    bus.cfg_valid = 1'b1;
    bus.cfg_data  = addr;
    wait_c = 0;
    acc = 1'b0;
    while (!acc && wait_c < 50) begin
      @(negedge prog_clk);
      if (wait_c == 0) begin
        chk("idle_busy", bus.busy, 0);
        chk("idle_done", bus.done, 0);
      end
      acc = bus.cfg_ready;
      @(posedge prog_clk); #1;
      wait_c++;
    end
    chk("addr_wait", wait_c, 1);

    ncyc = 1;
    gaps = 0;
    for (int k = 0; k < NB; k++) begin
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      for (int i = 0; i < g; i++) begin
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = 8'($urandom);
        @(negedge prog_clk);
        chk("gap_ready", bus.cfg_ready, 1);
        chk("gap_busy", bus.busy, 1);
        chk("gap_wl", bus.wl, 0);
        @(posedge prog_clk); #1;
        ncyc++;
        gaps++;
      end
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = fd[k];
      @(negedge prog_clk);
      chk("load_ready", bus.cfg_ready, 1);
      chk("load_busy", bus.busy, 1);
      chk("load_wl", bus.wl, 0);
      @(posedge prog_clk); #1;
      ncyc++;
    end
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = 8'($urandom);

    @(negedge prog_clk);
    chk("setup_ready", bus.cfg_ready, 0);
    chk("setup_wl", bus.wl, 0);
    chk("setup_done", bus.done, 0);
    chk("setup_bl", bus.bl, exp_bl);
    @(posedge prog_clk); #1;
    ncyc++;

    for (int p = 0; p < PC; p++) begin
      @(negedge prog_clk);
      chk("pulse_wl", bus.wl, exp_wl);
      chk("pulse_ready", bus.cfg_ready, 0);
      chk("pulse_done", bus.done, 0);
      chk("pulse_bl", bus.bl, exp_bl);
      if (abort_in_pulse) begin
        #2 prog_rst_n = 1'b0;
        #1;
        chk("arst_wl", bus.wl, 0);
        chk("arst_bl", bus.bl, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_ready", bus.cfg_ready, 0);
        $display("frame addr=%02h aborted by reset during pulse", addr);
        return;
      end
      @(posedge prog_clk); #1;
      ncyc++;
    end

    @(negedge prog_clk);
    chk("hold_done", bus.done, 1);
    chk("hold_err", bus.addr_err, (row >= WLW) ? 1 : 0);
    chk("hold_wl", bus.wl, 0);
    chk("hold_ready", bus.cfg_ready, 0);
    chk("hold_busy", bus.busy, 1);
    chk("hold_bl", bus.bl, exp_bl);
    @(posedge prog_clk); #1;
    ncyc++;
    chk("frame_len", ncyc, 1 + NB + 2 + PC + gaps);
    last_bl = exp_bl;
    $display("frame addr=%02h row=%0d gaps=%0d cycles=%0d", addr, row, gaps, ncyc);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < NB; k++) fd[k] = 8'($urandom);
  endtask

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    last_bl = '0;
    release_reset();

    for (int k = 0; k < NB; k++) fd[k] = 8'hA5;
    frame(8'h00, 0, 1'b0);

    for (int k = 0; k < NB; k++) fd[k] = 8'(k + 1);
    frame(8'h00, 0, 1'b0);
    frame(8'h01, 0, 1'b0);
    frame(8'h23, 0, 1'b0);
    frame(8'h47, 0, 1'b0);

    fill_rand();
    frame(8'h64, 0, 1'b0);
    fill_rand();
    frame(8'h48, 0, 1'b0);
    fill_rand();
    frame(8'h85, 0, 1'b0);
    fill_rand();
    frame(8'h7F, 0, 1'b0);

    fill_rand();
    frame(8'h2A, 0, 1'b0);
    frame(8'h2A, 5, 1'b0);
    fill_rand();
    frame(8'h11, 5, 1'b0);

    fill_rand();
    frame(8'h05, 0, 1'b1);
    release_reset();
    fill_rand();
    frame(8'h07, 0, 1'b0);

    repeat (3) begin
      @(negedge prog_clk);
      chk("idle_keep_bl", bus.bl, last_bl);
      chk("idle_wl", bus.wl, 0);
      @(posedge prog_clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
